spi_mem_loader: RTL and testbench
=================================

# spi_mem_loader

SPI-slave memory loader that drives the interface-side port of the data-memory wrapper (the `from_intf_mem_ctrl_*` / `to_intf_mem_ctrl_*` signals) and owns `core_select`. An external host uses it to download a program or data image into DFFRAM, read it back, and then release memory to the core. It oversamples a mode-0 SPI bus on the system clock and turns serial commands into single-word memory transactions with auto-incrementing addresses.

## Interface
- DATA_LENGTH, 32, memory word width; the wire protocol carries 32-bit words.
- ADDRESS_LENGTH, 32, width of `mem_address`; the wire carries a 32-bit address, and the low ADDRESS_LENGTH bits are used.

- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- spi_sclk  in  1  SPI clock, asynchronous to clk; mode 0.
- spi_cs_n  in  1  chip select, active-low, asynchronous.
- spi_mosi  in  1  host-to-loader serial data, MSB first.
- spi_miso  out  1  loader-to-host serial data, MSB first.
- core_select  out  1  1 gives memory to the core, 0 gives it to this block.
- mem_en  out  1  memory enable strobe to the wrapper interface port.
- mem_wr_en  out  1  write enable.
- mem_rd_en  out  1  read enable.
- mem_address  out  ADDRESS_LENGTH  word address, not shifted.
- mem_data_in  out  DATA_LENGTH  write data to memory.
- mem_data_length  out  2  access size; always 2'b11 (full word, byte mask 4'b1111).
- mem_data_out  in  DATA_LENGTH  read data from the wrapper.
- busy  out  1  high while a transaction is in progress (any state other than IDLE).

## Operation
- Input sync: spi_sclk, spi_cs_n and spi_mosi each pass through a 2-FF synchronizer. SCLK rise and fall are detected from the synchronized value (cycle of detection = E).
- Transaction framing: a synchronized cs_n falling edge moves IDLE to CMD, with bit counter = 0. A synchronized cs_n high forces IDLE from any state. A partially received word is discarded and nothing is written.
- Byte 0 is the command:
  - 0x02 WRITE: go to ADDR, then WDATA.
  - 0x03 READ: go to ADDR, then RDATA.
  - 0xA5 RUN: set core_select=1 when cs_n rises.
  - 0x5A HALT: clear core_select to 0 immediately, on the cycle after the command byte completes.
  - Any other value: go to IGNORE.
- WRITE or READ received while core_select=1: go to IGNORE. No memory access is made and MISO stays 0.
- ADDR state: shift in 32 bits MSB first, then load the address register with the low ADDRESS_LENGTH bits.
- WDATA state: shift in 32 bits, then issue a write strobe. The address then increments by 1 and wraps modulo 2^ADDRESS_LENGTH. Repeat for every further word until cs_n rises.
- RDATA state:
  - On the SCLK rise that samples the last address bit, issue a read strobe.
  - The captured word is loaded into the TX shift register and its MSB is presented on MISO at the next SCLK fall.
  - On the SCLK rise that samples bit 0 of each outgoing word, issue a read of address+1 (prefetch) and increment the address.
  - MOSI is ignored in RDATA.
- MISO changes only on detected SCLK falls. It is 0 in IDLE, CMD, ADDR, WDATA and IGNORE.
- Only one memory strobe is ever in flight. mem_wr_en and mem_rd_en are never high together.

## Timing
- Reset values:
  - core_select=0.
  - mem_en, mem_wr_en and mem_rd_en = 0.
  - mem_address=0, mem_data_in=0.
  - mem_data_length=2'b11.
  - spi_miso=0, busy=0.
  - FSM in IDLE; shift registers and counters at 0.
- Reset mid-transaction aborts with no memory strobe issued. Any strobe already in progress is dropped in the reset cycle.
- SPI constraint: SCLK high and low times must each be at least 4 clk periods (f_sclk ≤ f_clk/8). Behaviour above this rate is unspecified.
- Latency from an SCLK edge at the pin to its detection is 2–3 clk.
- Write: the word's last bit is detected at E.
  - E+1: mem_en=1, mem_wr_en=1, mem_address and mem_data_in valid.
  - E+2: strobes return to 0 and the address increments.
- Read: the triggering rise is detected at E.
  - E+1: mem_en=1, mem_rd_en=1.
  - E+2: mem_en=0, mem_rd_en stays 1, and mem_data_out is captured into the TX register at the end of the cycle.
  - E+3: mem_rd_en=0. The capture completes before the next SCLK fall detection (≥E+4).
- core_select on RUN: changes on the cycle the cs_n rise is detected.
- A cs_n rise in the same cycle as a last-bit SCLK rise: cs_n wins and no strobe is issued.

## Test plan
- Reset check: hold rst_n=0 for 2 clk while toggling the SPI inputs -> all outputs stay at their reset values; the first cycle after release has busy=0.
- Write burst: CS low, send 0x02, address 0x00000010, data 0xDEADBEEF, 0x12345678 -> two single-cycle write strobes, at addresses 0x10 then 0x11, with those data and mem_data_length=2'b11.
- Read burst: memory preloaded with 0x10=0xDEADBEEF, 0x11=0x12345678. Send 0x03, address 0x10, clock 64 bits -> MISO returns 0xDEADBEEF then 0x12345678. Read strobes go to 0x10, 0x11, 0x12 (the last one is a prefetch).
- Abort and wrap: WRITE to address 0xFFFFFFFF with one full word plus 12 bits, then CS high -> one write at 0xFFFFFFFF, address wraps to 0, no second write, busy=0 within 3 clk.
- RUN/HALT gating: send 0xA5 -> core_select=1 after CS rise. A following WRITE produces no strobes. 0x5A -> core_select=0, after which a WRITE succeeds.
- Unknown command 0x77 followed by 40 bits -> no memory activity, MISO stays 0, return to IDLE on CS high.

Source files
------------

// File: rtl/spi_mem_loader.sv
// -----------------------------------------------------------------------------
// spi_mem_loader
//
// SPI-slave (mode 0) memory loader. A host downloads an image into the data
// memory through the wrapper's interface-side port, reads it back, and then
// hands the memory over to the core via core_select. The SPI pins are
// oversampled on clk through 2-FF synchronizers; every memory access is a
// single full-word strobe with an auto-incrementing word address.
//
// Wire protocol (one frame per cs_n low period, MSB first):
//   0x02 WRITE : 32-bit address, then 32-bit words until cs_n rises
//   0x03 READ  : 32-bit address, then words are shifted out on MISO
//   0xA5 RUN   : core_select goes to 1 when cs_n rises
//   0x5A HALT  : core_select goes to 0 right after the command byte
//   others     : ignored until cs_n rises
//
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   spi_sclk/cs_n/mosi   asynchronous SPI inputs
//   spi_miso             serial read data, changes on SCLK falls only
//   core_select          1 = memory owned by core, 0 = owned by this block
//   mem_en/wr_en/rd_en   memory strobes to the wrapper interface port
//   mem_address          word address (not byte-shifted)
//   mem_data_in          write data
//   mem_data_length      access size, fixed to full word (2'b11)
//   mem_data_out         read data returned by the wrapper
//   busy                 high whenever the frame FSM is not idle
// -----------------------------------------------------------------------------
module spi_mem_loader #(
    parameter int DATA_LENGTH    = 32,  // must be <= 32 (wire word is 32 bits)
    parameter int ADDRESS_LENGTH = 32   // must be <= 32 (wire address is 32 bits)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_sclk,
    input  logic                      spi_cs_n,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic                      core_select,
    output logic                      mem_en,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [ADDRESS_LENGTH-1:0] mem_address,
    output logic [DATA_LENGTH-1:0]    mem_data_in,
    output logic [1:0]                mem_data_length,
    input  logic [DATA_LENGTH-1:0]    mem_data_out,
    output logic                      busy
);

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RUN   = 8'hA5;
    localparam logic [7:0] CMD_HALT  = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    // Synchronizers plus one extra stage for edge detection.
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_cs_meta,   r_cs_sync,   r_cs_prev;
    logic r_mosi_meta, r_mosi_sync;

    state_t                    r_state;
    logic [4:0]                r_bit_cnt;
    logic [30:0]               r_rx;          // only 31 bits kept; the 32nd is the live MOSI bit
    logic [31:0]               r_tx;
    logic                      r_is_read;
    logic                      r_run_pending;
    logic [1:0]                r_rd_phase;    // 0 idle, 1 = E+1 (en high), 2 = E+2 (capture)
    logic                      r_miso;
    logic                      r_core_select;
    logic                      r_mem_en;
    logic                      r_mem_wr_en;
    logic                      r_mem_rd_en;
    logic [ADDRESS_LENGTH-1:0] r_mem_address;
    logic [DATA_LENGTH-1:0]    r_mem_data_in;

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_cs_fall;
    logic        w_cs_rise;
    logic [31:0] w_rx_next;

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
    assign w_cs_fall   = ~r_cs_sync & r_cs_prev;
    assign w_cs_rise   = r_cs_sync & ~r_cs_prev;
    // Full word including the bit being sampled on this SCLK rise.
    assign w_rx_next   = {r_rx, r_mosi_sync};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_meta   <= 1'b0;
            r_sclk_sync   <= 1'b0;
            r_sclk_prev   <= 1'b0;
            // cs_n synchronizer parks deasserted so release never fakes a falling edge
            r_cs_meta     <= 1'b1;
            r_cs_sync     <= 1'b1;
            r_cs_prev     <= 1'b1;
            r_mosi_meta   <= 1'b0;
            r_mosi_sync   <= 1'b0;
            r_state       <= S_IDLE;
            r_bit_cnt     <= 5'd0;
            r_rx          <= '0;
            r_tx          <= '0;
            r_is_read     <= 1'b0;
            r_run_pending <= 1'b0;
            r_rd_phase    <= 2'd0;
            r_miso        <= 1'b0;
            r_core_select <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_sclk_meta <= spi_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_cs_meta   <= spi_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;

            // Write strobe lasts one cycle; address advances as it retires.
            if (r_mem_wr_en) begin
                r_mem_en      <= 1'b0;
                r_mem_wr_en   <= 1'b0;
                r_mem_address <= r_mem_address + ADDRESS_LENGTH'(1);
            end

            // Read: en for one cycle, rd_en for two, data captured at end of the second.
            case (r_rd_phase)
                2'd1: begin
                    r_mem_en   <= 1'b0;
                    r_rd_phase <= 2'd2;
                end
                2'd2: begin
                    r_mem_rd_en <= 1'b0;
                    r_tx        <= 32'(mem_data_out);
                    r_rd_phase  <= 2'd0;
                end
                default: ;
            endcase

            if (r_cs_sync) begin
                // Deselected: abandon any partial word, no strobe issued.
                r_state       <= S_IDLE;
                r_bit_cnt     <= 5'd0;
                r_miso        <= 1'b0;
                r_run_pending <= 1'b0;
                if (w_cs_rise && r_run_pending) begin
                    r_core_select <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= S_CMD;
                            r_bit_cnt <= 5'd0;
                            r_rx      <= '0;
                        end
                    end

                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_rx <= w_rx_next[30:0];
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= 5'd0;
                                case (w_rx_next[7:0])
                                    CMD_WRITE, CMD_READ: begin
                                        r_is_read <= (w_rx_next[7:0] == CMD_READ);
                                        // Memory belongs to the core: refuse access.
                                        r_state   <= r_core_select ? S_IGNORE : S_ADDR;
                                    end
                                    CMD_RUN: begin
                                        r_run_pending <= 1'b1;
                                        r_state       <= S_IGNORE;
                                    end
                                    CMD_HALT: begin
                                        r_core_select <= 1'b0;
                                        r_state       <= S_IGNORE;
                                    end
                                    default: r_state <= S_IGNORE;
                                endcase
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    S_ADDR: begin
                        if (w_sclk_rise) begin
                            r_rx <= w_rx_next[30:0];
                            if (r_bit_cnt == 5'd31) begin
                                r_bit_cnt     <= 5'd0;
                                r_mem_address <= w_rx_next[ADDRESS_LENGTH-1:0];
                                if (r_is_read) begin
                                    // First read goes out right away so the word is
                                    // ready before the next SCLK fall.
                                    r_state     <= S_RDATA;
                                    r_mem_en    <= 1'b1;
                                    r_mem_rd_en <= 1'b1;
                                    r_rd_phase  <= 2'd1;
                                end else begin
                                    r_state <= S_WDATA;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    S_WDATA: begin
                        if (w_sclk_rise) begin
                            r_rx <= w_rx_next[30:0];
                            if (r_bit_cnt == 5'd31) begin
                                r_bit_cnt     <= 5'd0;
                                r_mem_data_in <= w_rx_next[DATA_LENGTH-1:0];
                                r_mem_en      <= 1'b1;
                                r_mem_wr_en   <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    S_RDATA: begin
                        if (w_sclk_fall) begin
                            r_miso <= r_tx[31];
                            r_tx   <= {r_tx[30:0], 1'b0};
                        end
                        if (w_sclk_rise) begin
                            if (r_bit_cnt == 5'd31) begin
                                // Host just sampled bit 0: prefetch the next word.
                                r_bit_cnt     <= 5'd0;
                                r_mem_address <= r_mem_address + ADDRESS_LENGTH'(1);
                                r_mem_en      <= 1'b1;
                                r_mem_rd_en   <= 1'b1;
                                r_rd_phase    <= 2'd1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    S_IGNORE: ;

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign spi_miso        = r_miso;
    assign core_select     = r_core_select;
    assign mem_en          = r_mem_en;
    assign mem_wr_en       = r_mem_wr_en;
    assign mem_rd_en       = r_mem_rd_en;
    assign mem_address     = r_mem_address;
    assign mem_data_in     = r_mem_data_in;
    assign mem_data_length = 2'b11;
    assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_loader
//
// Directed bench for spi_mem_loader. A bit-banged mode-0 SPI host sends
// frames; a word memory stands in for the wrapper. Expected memory strobes
// are queued from the frame contents and checked every cycle a strobe is
// visible; read-back words come from a reference memory updated by the
// expected writes, with literal values pinning the key results.
// -----------------------------------------------------------------------------
module tb_spi_mem_loader;

    localparam int HALF = 6;  // SCLK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        core_select;
    logic        mem_en;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_data_length;
    logic [31:0] mem_data_out;
    logic        busy;

    always #5 clk = ~clk;

    spi_mem_loader #(
        .DATA_LENGTH    (32),
        .ADDRESS_LENGTH (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi_sclk        (spi_sclk),
        .spi_cs_n        (spi_cs_n),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .core_select     (core_select),
        .mem_en          (mem_en),
        .mem_wr_en       (mem_wr_en),
        .mem_rd_en       (mem_rd_en),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_data_length (mem_data_length),
        .mem_data_out    (mem_data_out),
        .busy            (busy)
    );

    // Stand-in for the memory wrapper: registered read, indexed by low address bits.
    logic [31:0] dut_mem [256] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en && mem_wr_en) dut_mem[mem_address[7:0]] <= mem_data_in;
        if (mem_en && mem_rd_en) mem_data_out <= dut_mem[mem_address[7:0]];
    end

    // Reference model state.
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } strobe_t;
    strobe_t exp_q[$];

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    logic tx_bits[$];
    logic rx_bits[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        strobe_t s;
        s.is_wr = 1'b1;
        s.addr  = a;
        s.data  = d;
        exp_q.push_back(s);
        ref_mem[a[7:0]] = d;
    endtask

    task automatic exp_rd(input logic [31:0] a);
        strobe_t s;
        s.is_wr = 1'b0;
        s.addr  = a;
        s.data  = 32'h0;
        exp_q.push_back(s);
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tx_bits.push_back(v[i]);
    endtask

    function automatic logic [31:0] rx_word(input int start);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 32; i++) w = {w[30:0], rx_bits[start + i]};
        return w;
    endfunction

    function automatic logic rx_any(input int from, input int upto);
        logic r;
        r = 1'b0;
        for (int i = from; i < upto; i++) r = r | rx_bits[i];
        return r;
    endfunction

    // Per-cycle strobe checker against the expected-strobe queue.
    initial begin : strobe_monitor
        logic    prev_en;
        strobe_t s;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (mem_en || mem_rd_en || mem_wr_en) begin
                    chk("wr_rd_exclusive", 64'(mem_wr_en & mem_rd_en), 64'd0);
                    chk("data_length", 64'(mem_data_length), 64'd3);
                end
                if (mem_en) begin
                    chk("strobe_single_cycle", 64'(prev_en), 64'd0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_strobe: got wr=%0b rd=%0b addr=%0h expected no strobe",
                                 mem_wr_en, mem_rd_en, mem_address);
                    end else begin
                        s = exp_q.pop_front();
                        chk("strobe_wr_en", 64'(mem_wr_en), 64'(s.is_wr));
                        chk("strobe_rd_en", 64'(mem_rd_en), 64'(!s.is_wr));
                        chk("strobe_addr", 64'(mem_address), 64'(s.addr));
                        if (s.is_wr) chk("strobe_wdata", 64'(mem_data_in), 64'(s.data));
                    end
                end
            end
            prev_en = mem_en;
        end
    end

    // Lower cs_n, shift every queued bit, leave cs_n low.
    task automatic frame_body();
        rx_bits.delete();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        foreach (tx_bits[i]) begin
            spi_mosi = tx_bits[i];
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b1;
            rx_bits.push_back(spi_miso);
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
        repeat (HALF) @(negedge clk);
        chk("busy_in_frame", 64'(busy), 64'd1);
    endtask

    // Raise cs_n; the FSM must be idle within 3 clk.
    task automatic frame_end(input string tag);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_after_cs_rise", 64'(busy), 64'd0);
        chk("all_strobes_seen", 64'(exp_q.size()), 64'd0);
        $display("frame %s: %0d bits, core_select=%0b, addr=%0h", tag, tx_bits.size(), core_select, mem_address);
        tx_bits.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("reset_ctrl", 64'({core_select, mem_en, mem_wr_en, mem_rd_en, spi_miso, busy}), 64'd0);
        chk("reset_addr", 64'(mem_address), 64'd0);
        chk("reset_wdata", 64'(mem_data_in), 64'd0);
        chk("reset_length", 64'(mem_data_length), 64'd3);
    endtask

    initial begin : main
        logic [31:0] w0, w1;

        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);

        // Reset: toggle SPI pins while held in reset.
        for (int c = 0; c < 2; c++) begin
            spi_sclk = ~spi_sclk;
            spi_mosi = ~spi_mosi;
            spi_cs_n = ~spi_cs_n;
            @(negedge clk);
            check_reset_outputs();
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("busy_first_cycle", 64'(busy), 64'd0);
        mon_on = 1'b1;
        repeat (4) @(negedge clk);

        // Write burst at 0x10.
        exp_wr(32'h10, 32'hDEADBEEF);
        exp_wr(32'h11, 32'h12345678);
        push_bits(32'h02, 8);
        push_bits(32'h10, 32);
        push_bits(32'hDEADBEEF, 32);
        push_bits(32'h12345678, 32);
        frame_body();
        chk("wr_miso_zero", 64'(rx_any(0, rx_bits.size())), 64'd0);
        frame_end("write_burst");
        chk("wr_addr_after", 64'(mem_address), 64'h12);

        // Read burst at 0x10, 64 clocks of data plus prefetch of 0x12.
        exp_rd(32'h10);
        exp_rd(32'h11);
        exp_rd(32'h12);
        push_bits(32'h03, 8);
        push_bits(32'h10, 32);
        push_bits(32'h0, 32);
        push_bits(32'h0, 32);
        frame_body();
        w0 = rx_word(40);
        w1 = rx_word(72);
        chk("rd_hdr_miso_zero", 64'(rx_any(0, 40)), 64'd0);
        chk("rd_word0", 64'(w0), 64'(ref_mem[8'h10]));
        chk("rd_word1", 64'(w1), 64'(ref_mem[8'h11]));
        chk("rd_word0_literal", 64'(w0), 64'hDEADBEEF);
        chk("rd_word1_literal", 64'(w1), 64'h12345678);
        frame_end("read_burst");

        // Wrap: one full word at 0xFFFFFFFF, then 12 bits discarded.
        exp_wr(32'hFFFF_FFFF, 32'hA5A5_0F0F);
        push_bits(32'h02, 8);
        push_bits(32'hFFFF_FFFF, 32);
        push_bits(32'hA5A5_0F0F, 32);
        push_bits(32'hABC, 12);
        frame_body();
        frame_end("abort_wrap");
        chk("wrap_addr_zero", 64'(mem_address), 64'd0);

        // RUN: core_select only after cs_n rise.
        push_bits(32'hA5, 8);
        frame_body();
        chk("run_before_cs_rise", 64'(core_select), 64'd0);
        frame_end("run");
        chk("run_core_select", 64'(core_select), 64'd1);

        // WRITE while core owns memory: no strobes (monitor flags any).
        push_bits(32'h02, 8);
        push_bits(32'h21, 32);
        push_bits(32'hCAFEF00D, 32);
        frame_body();
        chk("gated_miso_zero", 64'(rx_any(0, rx_bits.size())), 64'd0);
        frame_end("gated_write");
        chk("gated_core_select", 64'(core_select), 64'd1);

        // HALT: core_select clears before cs_n rises.
        push_bits(32'h5A, 8);
        frame_body();
        chk("halt_immediate", 64'(core_select), 64'd0);
        frame_end("halt");

        // WRITE now succeeds.
        exp_wr(32'h20, 32'h0BADF00D);
        push_bits(32'h02, 8);
        push_bits(32'h20, 32);
        push_bits(32'h0BADF00D, 32);
        frame_body();
        frame_end("write_after_halt");

        // Unknown command followed by 40 bits.
        push_bits(32'h77, 8);
        push_bits(32'hFFFF_FFFF, 32);
        push_bits(32'hFF, 8);
        frame_body();
        chk("unknown_miso_zero", 64'(rx_any(0, rx_bits.size())), 64'd0);
        frame_end("unknown_cmd");

        // Read back 0x20/0x21: the gated write to 0x21 must not have landed.
        exp_rd(32'h20);
        exp_rd(32'h21);
        exp_rd(32'h22);
        push_bits(32'h03, 8);
        push_bits(32'h20, 32);
        push_bits(32'h0, 32);
        push_bits(32'h0, 32);
        frame_body();
        w0 = rx_word(40);
        w1 = rx_word(72);
        chk("rd2_word0", 64'(w0), 64'(ref_mem[8'h20]));
        chk("rd2_word1", 64'(w1), 64'(ref_mem[8'h21]));
        chk("rd2_word0_literal", 64'(w0), 64'h0BADF00D);
        chk("rd2_gated_literal", 64'(w1), 64'h0);
        frame_end("read_back");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
